// File: rtl/sobel_result_writer_pkg.sv
// sobel_pkg: shared types and constants for the Sobel result writer.
//   state_e   - writer FSM states (IDLE, RUN, FLUSH)
//   PIX_W     - pixel width in bits
//   WORD_W    - packed memory word width in bits
//   PIX_PER_WORD - pixels packed into one memory word
//   out_pix() - number of valid Sobel output pixels for a given image size
//   out_words() - number of packed words needed for one frame
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int PIX_W        = 8;
  localparam int WORD_W       = 32;
  localparam int PIX_PER_WORD = 4;

  // A 3x3 kernel loses one pixel on every border.
  function automatic int out_pix(input int width, input int height);
    return (width - 2) * (height - 2);
  endfunction

  function automatic int out_words(input int width, input int height);
    return (out_pix(width, height) + PIX_PER_WORD - 1) / PIX_PER_WORD;
  endfunction

endpackage

// File: rtl/sobel_result_writer_if.sv
// sobel_result_writer_if: frame-memory write port (valid/ready).
//   wr_addr_o  - word address
//   wr_data_o  - packed word, earliest pixel in [7:0]
//   wr_valid_o - write request
//   wr_ready_i - memory accepts when wr_valid_o & wr_ready_i
// master: the writer side; slave: the memory side.
interface sobel_result_writer_if #(
  parameter int ADDR_W = 16
) ();

  logic [ADDR_W-1:0]            wr_addr_o;
  logic [sobel_pkg::WORD_W-1:0] wr_data_o;
  logic                         wr_valid_o;
  logic                         wr_ready_i;

  modport master (
    output wr_addr_o,
    output wr_data_o,
    output wr_valid_o,
    input  wr_ready_i
  );

  modport slave (
    input  wr_addr_o,
    input  wr_data_o,
    input  wr_valid_o,
    output wr_ready_i
  );

endinterface

// File: rtl/sobel_result_writer_fifo.sv
// sobel_word_fifo: synchronous show-ahead FIFO with registered storage.
//   clk, rst - clock, asynchronous active-high reset
//   push/din - write request and data; ignored when full unless popping
//   pop      - read request; ignored when empty
//   full     - no free entry
//   empty    - no stored entry
//   dout     - head entry (valid whenever !empty)
// Push and pop together are accepted at any occupancy, including full.
module sobel_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en;
  logic             rd_en;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    rd_en    = pop && !empty;
    // When full, the slot being written is the one being vacated by the pop.
    wr_en    = push && (!full || rd_en);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/sobel_result_writer.sv
// sobel_result_writer: sink for the Sobel pixel stream.
// Packs one frame of 8-bit edge pixels four per 32-bit word, buffers the
// words in a small FIFO and writes them to consecutive word addresses.
//   clk, rst     - clock, asynchronous active-high reset
//   start_i      - one-cycle pulse, arms a new frame (IDLE only)
//   grayscale_i  - Sobel result pixel
//   done_i       - pixel strobe, grayscale_i valid this cycle
//   wr_if        - memory write port (address, data, valid/ready)
//   busy_o       - high in RUN or FLUSH
//   frame_done_o - one-cycle pulse after the last word is accepted
//   overflow_o   - sticky, a packed word was dropped (cleared by start_i)
module sobel_result_writer
  import sobel_pkg::*;
#(
  parameter int               IMG_WIDTH  = 256,
  parameter int               IMG_HEIGHT = 256,
  parameter int               ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int               FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [PIX_W-1:0]      grayscale_i,
  input  logic                  done_i,
  sobel_result_writer_if.master wr_if,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  overflow_o
);

  localparam int              OUT_PIX  = out_pix(IMG_WIDTH, IMG_HEIGHT);
  localparam int              CNT_W    = $clog2(OUT_PIX + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_PIX - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [WORD_W-1:0]   pack_q, pack_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ovf_q, ovf_d;

  logic [WORD_W-1:0]   lane_word;
  logic                pix_take;
  logic                last_pix;
  logic                start_take;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [WORD_W-1:0]   fifo_dout;

  sobel_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (lane_word),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign wr_if.wr_addr_o  = addr_q;
  assign wr_if.wr_data_o  = fifo_dout;
  assign wr_if.wr_valid_o = !fifo_empty;
  assign overflow_o       = ovf_q;

  // Packer, pixel counter, address and overflow tracking.
  always_comb begin
    // Current pack register with the incoming pixel merged into its lane;
    // lanes above idx are still zero, so this is also the pushed word.
    lane_word = pack_q;
    lane_word[{idx_q, 3'b000} +: PIX_W] = grayscale_i;

    pix_take   = (state_q == RUN) && done_i;
    last_pix   = (cnt_q == LAST_CNT);
    start_take = (state_q == IDLE) && start_i;
    fifo_push  = pix_take && ((idx_q == 2'd3) || last_pix);
    fifo_pop   = !fifo_empty && wr_if.wr_ready_i;

    cnt_d  = cnt_q;
    idx_d  = idx_q;
    pack_d = pack_q;
    addr_d = addr_q;
    ovf_d  = ovf_q;

    if (start_take) begin
      cnt_d  = '0;
      idx_d  = '0;
      pack_d = '0;
      addr_d = BASE_ADDR;
      ovf_d  = 1'b0;
    end

    if (pix_take) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (fifo_push) begin
        idx_d  = '0;
        pack_d = '0;
      end else begin
        idx_d  = idx_q + 2'd1;
        pack_d = lane_word;
      end
    end

    if (fifo_pop) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    // The word is lost but still counted, so the frame ends normally.
    if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (fifo_push && last_pix) state_d = FLUSH;
      // FLUSH is always entered with at least one word buffered, so reaching
      // empty here means the final word has just been accepted.
      FLUSH:   if (fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_o       = (state_q != IDLE);
    frame_done_o = (state_q == FLUSH) && fifo_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pack_q <= '0;
      addr_q <= BASE_ADDR;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pack_q <= pack_d;
      addr_q <= addr_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sobel_result_writer.sv
// Testbench for sobel_result_writer. Four instances:
//   0: 6x6, FIFO 8, base 0      (basic, stall, restart, reset mid-frame)
//   1: 5x5, FIFO 8, base 0      (partial last word)
//   2: 6x6, FIFO 2, base 0      (overflow)
//   3: 6x6, FIFO 8, base 0xFFFE (address wrap)
// Stimulus pushes expected writes and signal checks into queues; a single
// monitor on the falling edge pops and compares them.
module tb_sobel_result_writer;
  import sobel_pkg::*;

  localparam int NDUT = 4;
  localparam int K_BUSY = 0, K_OVF = 1, K_VALID = 2, K_ADDR = 3,
                 K_FD = 4, K_QLEFT = 5, K_FDCNT = 6, K_DATA = 7;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    bit          last;
  } wr_t;

  typedef struct {
    int          g;
    int          kind;
    logic [31:0] exp;
    string       name;
  } sig_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0]        rst_r, start_r, done_r, ready_r;
  logic [NDUT-1:0][7:0]   pix_r;
  logic [NDUT-1:0]        valid_w, busy_w, fd_w, ovf_w;
  logic [NDUT-1:0][15:0]  addr_w;
  logic [NDUT-1:0][31:0]  data_w;
  bit                     toggle_a;

  wr_t  exp_q [NDUT][$];
  sig_t sig_q [$];
  int   fd_cnt [NDUT];
  bit   pend [NDUT];
  int   n_checks = 0;
  int   n_errors = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sobel_result_writer_if #(.ADDR_W(16)) wif ();

    sobel_result_writer #(
      .IMG_WIDTH  (g == 1 ? 5 : 6),
      .IMG_HEIGHT (g == 1 ? 5 : 6),
      .ADDR_W     (16),
      .BASE_ADDR  (g == 3 ? 16'hFFFE : 16'h0000),
      .FIFO_DEPTH (g == 2 ? 2 : 8)
    ) dut (
      .clk          (clk),
      .rst          (rst_r[g]),
      .start_i      (start_r[g]),
      .grayscale_i  (pix_r[g]),
      .done_i       (done_r[g]),
      .wr_if        (wif),
      .busy_o       (busy_w[g]),
      .frame_done_o (fd_w[g]),
      .overflow_o   (ovf_w[g])
    );

    assign wif.wr_ready_i = ready_r[g];
    assign valid_w[g]     = wif.wr_valid_o;
    assign addr_w[g]      = wif.wr_addr_o;
    assign data_w[g]      = wif.wr_data_o;
  end

  function automatic logic [15:0] base_of(input int g);
    return (g == 3) ? 16'hFFFE : 16'h0000;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input int g,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h", name, g, act, exp);
    end
  endtask

  always @(negedge clk) begin
    sig_t        s;
    wr_t         w;
    logic [31:0] act;
    while (sig_q.size() > 0) begin
      s = sig_q.pop_front();
      case (s.kind)
        K_BUSY:  act = 32'(busy_w[s.g]);
        K_OVF:   act = 32'(ovf_w[s.g]);
        K_VALID: act = 32'(valid_w[s.g]);
        K_ADDR:  act = 32'(addr_w[s.g]);
        K_FD:    act = 32'(fd_w[s.g]);
        K_QLEFT: act = 32'(exp_q[s.g].size());
        K_FDCNT: act = 32'(fd_cnt[s.g]);
        default: act = data_w[s.g];
      endcase
      chk(s.name, s.g, act, s.exp);
    end
    for (int g = 0; g < NDUT; g++) begin
      if (rst_r[g]) begin
        exp_q[g].delete();
        pend[g] = 1'b0;
      end else begin
        if (pend[g] || fd_w[g]) chk("frame_done_timing", g, 32'(fd_w[g]), 32'(pend[g]));
        if (fd_w[g]) fd_cnt[g]++;
        pend[g] = 1'b0;
        if (valid_w[g]) begin
          if (exp_q[g].size() == 0) begin
            chk("write_expected", g, 32'(valid_w[g]), 32'd0);
          end else begin
            w = exp_q[g][0];
            chk("wr_addr", g, 32'(addr_w[g]), 32'(w.addr));
            chk("wr_data", g, data_w[g], w.data);
            if (ready_r[g]) begin
              void'(exp_q[g].pop_front());
              if (w.last) pend[g] = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_a) ready_r[0] = ~ready_r[0];
  endtask

  task automatic expect_sig(input int g, input int kind,
                            input logic [31:0] v, input string name);
    sig_t s;
    s.g = g; s.kind = kind; s.exp = v; s.name = name;
    sig_q.push_back(s);
  endtask

  task automatic expect_word(input int g, input logic [15:0] a,
                             input logic [31:0] d, input bit last);
    wr_t w;
    w.addr = a; w.data = d; w.last = last;
    exp_q[g].push_back(w);
  endtask

  // Expected writes for a frame of npix pixels first, first+1, ...; only
  // the first nkept words reach memory.
  task automatic expect_frame(input int g, input logic [15:0] base,
                              input int first, input int npix, input int nkept);
    logic [31:0] d;
    logic [7:0]  p;
    for (int w = 0; w < nkept; w++) begin
      d = '0;
      for (int b = 0; b < 4; b++) begin
        if (4 * w + b < npix) begin
          p = 8'(first + 4 * w + b);
          d = d | (32'(p) << (8 * b));
        end
      end
      expect_word(g, base + 16'(w), d, (w == nkept - 1));
    end
  endtask

  task automatic pixel(input int g, input logic [7:0] p);
    pix_r[g]  = p;
    done_r[g] = 1'b1;
    tick();
    done_r[g] = 1'b0;
  endtask

  task automatic send_pixels(input int g, input int first, input int n);
    for (int i = 0; i < n; i++) pixel(g, 8'(first + i));
  endtask

  task automatic pulse_start(input int g);
    start_r[g] = 1'b1;
    tick();
    start_r[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    for (int n = 0; n < 400 && busy_w[g]; n++) tick();
  endtask

  task automatic end_checks(input int g, input int fds, input bit ovf);
    expect_sig(g, K_QLEFT, 32'd0, "words_left");
    expect_sig(g, K_FDCNT, 32'(fds), "frame_done_count");
    expect_sig(g, K_OVF, 32'(ovf), "overflow");
    expect_sig(g, K_BUSY, 32'd0, "busy_end");
    tick();
  endtask

  initial begin
    rst_r    = '1;
    start_r  = '0;
    done_r   = '0;
    ready_r  = '1;
    pix_r    = '0;
    toggle_a = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      fd_cnt[g] = 0;
      pend[g]   = 1'b0;
    end
    tick();
    tick();
    for (int g = 0; g < NDUT; g++) begin
      expect_sig(g, K_BUSY, 32'd0, "rst_busy");
      expect_sig(g, K_VALID, 32'd0, "rst_valid");
      expect_sig(g, K_OVF, 32'd0, "rst_overflow");
      expect_sig(g, K_FD, 32'd0, "rst_frame_done");
      expect_sig(g, K_ADDR, 32'(base_of(g)), "rst_addr");
      expect_sig(g, K_DATA, 32'd0, "rst_data");
    end
    tick();
    rst_r = '0;
    tick();

    // DUT0: pixels while IDLE produce nothing.
    send_pixels(0, 8'hA0, 5);
    tick();
    expect_sig(0, K_VALID, 32'd0, "idle_no_write");
    expect_sig(0, K_BUSY, 32'd0, "idle_busy");
    tick();

    // DUT0: basic frame, ready always high, first-word latency checked.
    expect_frame(0, 16'h0000, 8'h10, 16, 4);
    pulse_start(0);
    expect_sig(0, K_BUSY, 32'd1, "busy_run");
    for (int i = 0; i < 16; i++) begin
      pixel(0, 8'(8'h10 + i));
      if (i == 2) expect_sig(0, K_VALID, 32'd0, "valid_before_4th");
      if (i == 3) expect_sig(0, K_VALID, 32'd1, "valid_after_4th");
    end
    wait_idle(0);
    end_checks(0, 1, 1'b0);

    // Pixel after frame end is ignored.
    pixel(0, 8'h99);
    tick();
    expect_sig(0, K_VALID, 32'd0, "post_frame_no_write");
    tick();

    // DUT0: ready toggling, plus a start pulse mid-frame that must be ignored.
    expect_frame(0, 16'h0000, 8'h20, 16, 4);
    toggle_a = 1'b1;
    pulse_start(0);
    send_pixels(0, 8'h20, 5);
    pulse_start(0);
    send_pixels(0, 8'h25, 11);
    wait_idle(0);
    toggle_a   = 1'b0;
    ready_r[0] = 1'b1;
    end_checks(0, 2, 1'b0);

    // DUT0: reset after 7 pixels with the first word held in the FIFO.
    ready_r[0] = 1'b0;
    expect_word(0, 16'h0000, 32'h43424140, 1'b0);
    pulse_start(0);
    send_pixels(0, 8'h40, 7);
    rst_r[0] = 1'b1;
    expect_sig(0, K_VALID, 32'd0, "midrst_valid");
    expect_sig(0, K_BUSY, 32'd0, "midrst_busy");
    expect_sig(0, K_ADDR, 32'd0, "midrst_addr");
    expect_sig(0, K_FD, 32'd0, "midrst_frame_done");
    tick();
    rst_r[0]   = 1'b0;
    ready_r[0] = 1'b1;
    tick();
    expect_sig(0, K_VALID, 32'd0, "postrst_valid");
    expect_frame(0, 16'h0000, 8'h50, 16, 4);
    pulse_start(0);
    send_pixels(0, 8'h50, 16);
    wait_idle(0);
    end_checks(0, 3, 1'b0);

    // DUT1: 5x5 -> 9 pixels, partial last word, a 10th strobe ignored.
    expect_frame(1, 16'h0000, 8'h10, 9, 3);
    pulse_start(1);
    send_pixels(1, 8'h10, 10);
    wait_idle(1);
    end_checks(1, 1, 1'b0);

    // DUT2: FIFO depth 2, memory stalled for the whole frame.
    ready_r[2] = 1'b0;
    expect_frame(2, 16'h0000, 8'h10, 16, 2);
    pulse_start(2);
    send_pixels(2, 8'h10, 16);
    tick();
    tick();
    expect_sig(2, K_OVF, 32'd1, "overflow_set");
    expect_sig(2, K_BUSY, 32'd1, "busy_flush_stalled");
    tick();
    ready_r[2] = 1'b1;
    wait_idle(2);
    end_checks(2, 1, 1'b1);
    pulse_start(2);
    expect_sig(2, K_OVF, 32'd0, "overflow_cleared_by_start");
    tick();

    // DUT3: address wrap from 0xFFFE.
    expect_frame(3, 16'hFFFE, 8'h10, 16, 4);
    pulse_start(3);
    send_pixels(3, 8'h10, 16);
    wait_idle(3);
    end_checks(3, 1, 1'b0);

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
